// File: rtl/disp_msg_sequencer_if.sv
// Front-panel display/buzzer signal bundle.
// The slave modport is the sequencer side: it takes button levels and drives
// the digit, segment and buzzer pins plus status. The master modport is the
// side that supplies button levels and observes the pins.
interface disp_msg_sequencer_if;
  logic [4:0] req;       // debounced levels: bit0 err, bit1 off, bit2 on, bit3 open, bit4 sound
  logic [3:0] digit;     // one-hot active-high digit enable, digit[3] leftmost
  logic [7:0] segment;   // active-low {dp,g,f,e,d,c,b,a}
  logic       buzzer;    // active-high buzzer drive
  logic [2:0] msg_code;  // held message code
  logic       busy;      // beep pattern in progress

  modport master (
    output req,
    input  digit, segment, buzzer, msg_code, busy
  );

  modport slave (
    input  req,
    output digit, segment, buzzer, msg_code, busy
  );
endinterface

// File: rtl/disp_msg_sequencer.sv
// disp_msg_sequencer: front-panel message controller.
// Turns rising edges on five debounced buttons into one held message code,
// scans that message over a 4-digit multiplexed seven-segment display and
// plays a beep pattern per accepted event on the buzzer.
// Optional feature macro: DISP_DP_HEARTBEAT_EN -- when defined, a frame
// counter blinks the decimal point of the rightmost digit every 128 frames.
module disp_msg_sequencer #(
  parameter int REFRESH_DIV = 50000,   // clk cycles each digit stays enabled (>= 2)
  parameter int BEEP_CYCLES = 5000000  // clk cycles per beep and per gap (>= 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  disp_msg_sequencer_if.slave   io
);

  // Counter widths; both counters only need to reach their parameter minus one.
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BEEP_LAST    = BW'(BEEP_CYCLES - 1);

  // Message codes; the code of each event equals its request bit index.
  localparam logic [2:0] MSG_ERR   = 3'd0;
  localparam logic [2:0] MSG_OFF   = 3'd1;
  localparam logic [2:0] MSG_ON    = 3'd2;
  localparam logic [2:0] MSG_OPEN  = 3'd3;
  localparam logic [2:0] MSG_SOUND = 3'd4;
  localparam logic [2:0] MSG_BLANK = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEEP = 2'd1,
    ST_GAP  = 2'd2
  } beep_state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [4:0]    req_q;
  logic [2:0]    msg_q;
  logic [RW-1:0] refresh_q;
  logic [1:0]    scan_q;
  logic [3:0]    digit_q;
  logic [7:0]    segment_q;
  beep_state_t   state_q, state_d;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic [1:0]    remaining_q, remaining_d;

  // ---------------------------------------------------------------------------
  // Event detection and arbitration
  // ---------------------------------------------------------------------------
  logic [4:0] rise;
  logic       event_valid;
  logic [2:0] event_code;
  logic [1:0] event_beeps;

  assign rise = io.req & ~req_q;

  // Pick the highest-priority rising button; lower-priority rises in the same
  // cycle are simply dropped.
  always_comb begin
    event_valid = 1'b1;
    event_code  = MSG_BLANK;
    event_beeps = 2'd0;
    if (rise[0]) begin
      event_code  = MSG_ERR;
      event_beeps = 2'd2;
    end else if (rise[1]) begin
      event_code  = MSG_OFF;
      event_beeps = 2'd1;
    end else if (rise[2]) begin
      event_code  = MSG_ON;
      event_beeps = 2'd1;
    end else if (rise[3]) begin
      event_code  = MSG_OPEN;
      event_beeps = 2'd1;
    end else if (rise[4]) begin
      event_code  = MSG_SOUND;
      event_beeps = 2'd3;
    end else begin
      event_valid = 1'b0;
    end
  end

  // Remember last button levels and latch the accepted message until the next event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= 5'b00000;
      msg_q <= MSG_BLANK;
    end else begin
      req_q <= io.req;
      if (event_valid) begin
        msg_q <= event_code;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------------
  logic        scan_step;
  logic [31:0] msg_glyphs;
  logic [7:0]  glyph;
  logic [7:0]  segment_next;

  assign scan_step = (refresh_q == REFRESH_LAST);

  // Look up the four-character glyph string of the held message and pick the
  // character under the current scan position (position 0 is leftmost).
  always_comb begin
    msg_glyphs = 32'hFFFF_FFFF;
    case (msg_q)
      MSG_ERR:   msg_glyphs = 32'h86AF_AFFF;  // "Err "
      MSG_OFF:   msg_glyphs = 32'hFFC0_8E8E;  // " OFF"
      MSG_ON:    msg_glyphs = 32'hFFFF_C0AB;  // "  On"
      MSG_OPEN:  msg_glyphs = 32'hC08C_86AB;  // "OPEn"
      MSG_SOUND: msg_glyphs = 32'h92AB_A1FF;  // "Snd "
      default:   msg_glyphs = 32'hFFFF_FFFF;  // blank
    endcase
    case (scan_q)
      2'd0:    glyph = msg_glyphs[31:24];
      2'd1:    glyph = msg_glyphs[23:16];
      2'd2:    glyph = msg_glyphs[15:8];
      default: glyph = msg_glyphs[7:0];
    endcase
  end

`ifdef DISP_DP_HEARTBEAT_EN
  logic [7:0] frame_q;

  // Count completed frames (scan index wrapping from the rightmost digit back to the leftmost).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= 8'd0;
    end else if (scan_step && (scan_q == 2'd3)) begin
      frame_q <= frame_q + 8'd1;
    end
  end

  // Light the rightmost decimal point during the upper half of each 256-frame period.
  always_comb begin
    segment_next = glyph;
    if ((scan_q == 2'd3) && frame_q[7]) begin
      segment_next[7] = 1'b0;
    end
  end
`else
  // Decimal point stays dark; the glyph goes straight to the pins.
  always_comb begin
    segment_next = glyph;
  end
`endif

  // Advance the refresh counter and register digit and segment from the same
  // scan index so the enable and the pattern always change together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_q <= '0;
      scan_q    <= 2'd0;
      digit_q   <= 4'b0000;
      segment_q <= 8'hFF;
    end else begin
      digit_q   <= 4'b1000 >> scan_q;
      segment_q <= segment_next;
      if (scan_step) begin
        refresh_q <= '0;
        scan_q    <= scan_q + 2'd1;
      end else begin
        refresh_q <= refresh_q + RW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Beep sequencer
  // ---------------------------------------------------------------------------
  logic beep_last;

  assign beep_last = (beep_cnt_q == BEEP_LAST);

  // Beep state, phase counter and remaining-beep count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beep_cnt_q  <= '0;
      remaining_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      beep_cnt_q  <= beep_cnt_d;
      remaining_q <= remaining_d;
    end
  end

  // Next-state logic: a new event always restarts the pattern from the first
  // beep, abandoning whatever was playing.
  always_comb begin
    state_d     = state_q;
    beep_cnt_d  = beep_cnt_q;
    remaining_d = remaining_q;
    if (event_valid) begin
      state_d     = ST_BEEP;
      beep_cnt_d  = '0;
      remaining_d = event_beeps;
    end else begin
      case (state_q)
        ST_IDLE: begin
          beep_cnt_d = '0;
        end
        ST_BEEP: begin
          if (beep_last) begin
            beep_cnt_d  = '0;
            remaining_d = remaining_q - 2'd1;
            state_d     = (remaining_q == 2'd1) ? ST_IDLE : ST_GAP;
          end else begin
            beep_cnt_d = beep_cnt_q + BW'(1);
          end
        end
        ST_GAP: begin
          if (beep_last) begin
            beep_cnt_d = '0;
            state_d    = ST_BEEP;
          end else begin
            beep_cnt_d = beep_cnt_q + BW'(1);
          end
        end
        default: begin
          state_d     = ST_IDLE;
          beep_cnt_d  = '0;
          remaining_d = 2'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all taken directly from registers)
  // ---------------------------------------------------------------------------
  assign io.digit    = digit_q;
  assign io.segment  = segment_q;
  assign io.msg_code = msg_q;
  assign io.buzzer   = (state_q == ST_BEEP);
  assign io.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_disp_msg_sequencer.sv
// Testbench for disp_msg_sequencer with small REFRESH_DIV/BEEP_CYCLES.
// A timeline model derives every output from the edge count since reset and
// the start time of the latest accepted event; a compare process checks all
// outputs each cycle, and directed scenarios pin the model with literal values.
module tb_disp_msg_sequencer;
  localparam int R = 4;
  localparam int B = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  disp_msg_sequencer_if dif();

  disp_msg_sequencer #(.REFRESH_DIV(R), .BEEP_CYCLES(B)) dut (
    .clk (clk),
    .rst (rst),
    .io  (dif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", nm, act, exp, $time);
    end
  endtask

  // Glyph strings, leftmost character in the top byte.
  function automatic logic [7:0] glyph_of(input logic [2:0] c, input int pos);
    logic [31:0] w;
    case (c)
      3'd0:    w = 32'h86AFAFFF;
      3'd1:    w = 32'hFFC08E8E;
      3'd2:    w = 32'hFFFFC0AB;
      3'd3:    w = 32'hC08C86AB;
      3'd4:    w = 32'h92ABA1FF;
      default: w = 32'hFFFFFFFF;
    endcase
    return w[31-8*pos -: 8];
  endfunction

  // ---------------- timeline model ----------------
  int         t;          // clock edges since reset release
  logic [4:0] m_prev;
  logic [2:0] m_msg;
  int         pat_start, pat_cnt;
  int         idx, frames, k, ph, sel;
  logic [4:0] rise;
  logic [3:0] exp_digit;
  logic [7:0] exp_seg;
  logic [2:0] exp_msg;
  logic       exp_buz, exp_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t = 0; m_prev = 5'b0; m_msg = 3'd7; pat_start = 0; pat_cnt = 0;
      exp_digit = 4'b0000; exp_seg = 8'hFF; exp_msg = 3'd7; exp_buz = 1'b0; exp_busy = 1'b0;
    end else begin
      t++;
      idx = ((t - 1) / R) % 4;
      exp_digit = 4'b1000 >> idx;
      exp_seg = glyph_of(m_msg, idx);  // segment shows the message held before this edge
`ifdef DISP_DP_HEARTBEAT_EN
      frames = (t - 1) / (4 * R);
      if (idx == 3 && frames[7]) exp_seg[7] = 1'b0;
`endif
      rise = dif.req & ~m_prev;
      m_prev = dif.req;
      if (rise != 5'b0) begin
        sel = 0;
        for (int b = 4; b >= 0; b--) if (rise[b]) sel = b;
        m_msg = 3'(sel);
        pat_start = t;
        pat_cnt = (sel == 0) ? 2 : (sel == 4) ? 3 : 1;
      end
      exp_msg = m_msg;
      k  = t - pat_start;
      ph = k / B;
      exp_busy = (pat_cnt > 0) && (ph < 2 * pat_cnt - 1);
      exp_buz  = exp_busy && (ph % 2 == 0);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("digit",    32'(dif.digit),    32'(exp_digit));
      chk("segment",  32'(dif.segment),  32'(exp_seg));
      chk("msg_code", 32'(dif.msg_code), 32'(exp_msg));
      chk("buzzer",   32'(dif.buzzer),   32'(exp_buz));
      chk("busy",     32'(dif.busy),     32'(exp_busy));
    end
  end

  // Apply a request level, then observe n cycles starting at the edge that sees it.
  task automatic press_window(input logic [4:0] v, input int n,
                              output int nbuz, output int nbusy, output logic [2:0] first_msg);
    dif.req = v;
    nbuz = 0; nbusy = 0; first_msg = 3'd7;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) first_msg = dif.msg_code;
      if (dif.buzzer) nbuz++;
      if (dif.busy) nbusy++;
    end
  endtask

  task automatic idle(input int n);
    dif.req = 5'b0;
    repeat (n) @(negedge clk);
  endtask

  int nb, ny;
  logic [2:0] fm;
  logic [4:0] rv;

  initial begin
    dif.req = 5'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // 1: blank scan
    @(negedge clk);
    chk("first_digit", 32'(dif.digit), 32'h8);
    chk("first_seg", 32'(dif.segment), 32'hFF);
    repeat (4) @(negedge clk);
    chk("digit_edge5", 32'(dif.digit), 32'h4);
    repeat (12) @(negedge clk);
    chk("digit_wrap", 32'(dif.digit), 32'h8);
    chk("blank_msg", 32'(dif.msg_code), 32'h7);
    $display("tb: blank scan done, t=%0d", t);

    // 2: single on press held 20 cycles
    press_window(5'b00100, 20, nb, ny, fm);
    chk("on_msg", 32'(fm), 32'h2);
    chk("on_buzz", 32'(nb), 32'd8);
    chk("on_busy", 32'(ny), 32'd8);
    $display("tb: on press msg=%0d buzz=%0d busy=%0d", fm, nb, ny);
    idle(6);

    // 3: simultaneous err+off rise
    press_window(5'b00011, 30, nb, ny, fm);
    chk("erroff_msg", 32'(fm), 32'h0);
    chk("erroff_buzz", 32'(nb), 32'd16);
    chk("erroff_busy", 32'(ny), 32'd24);
    $display("tb: err+off msg=%0d buzz=%0d busy=%0d", fm, nb, ny);
    idle(6);

    // 4: sound pattern
    press_window(5'b10000, 45, nb, ny, fm);
    chk("sound_msg", 32'(fm), 32'h4);
    chk("sound_buzz", 32'(nb), 32'd24);
    chk("sound_busy", 32'(ny), 32'd40);
    $display("tb: sound msg=%0d buzz=%0d busy=%0d", fm, nb, ny);
    idle(6);

    // 5: err preempts sound during its second beep
    press_window(5'b10000, 20, nb, ny, fm);
    press_window(5'b10001, 30, nb, ny, fm);
    chk("preempt_msg", 32'(fm), 32'h0);
    chk("preempt_buzz", 32'(nb), 32'd16);
    chk("preempt_busy", 32'(ny), 32'd24);
    $display("tb: preempt msg=%0d buzz=%0d busy=%0d", fm, nb, ny);
    idle(6);

    // 6: asynchronous reset mid-beep
    dif.req = 5'b00010;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_digit", 32'(dif.digit), 32'h0);
    chk("rst_seg", 32'(dif.segment), 32'hFF);
    chk("rst_buzz", 32'(dif.buzzer), 32'h0);
    chk("rst_busy", 32'(dif.busy), 32'h0);
    chk("rst_msg", 32'(dif.msg_code), 32'h7);
    $display("tb: async reset applied mid-beep");
    @(negedge clk);
    dif.req = 5'b0;
    @(negedge clk);
    rst = 1'b0;

    // randomized button activity
    rv = 5'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) rv[$urandom_range(0, 4)] ^= 1'b1;
      dif.req = rv;
      @(negedge clk);
    end
    $display("tb: random phase done, t=%0d", t);

`ifdef DISP_DP_HEARTBEAT_EN
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (128 * 4 * R + 4) @(negedge clk);
    for (int i = 0; i < 4 * R && dif.digit != 4'b0001; i++) @(negedge clk);
    chk("hb_digit", 32'(dif.digit), 32'h1);
    chk("hb_dp", 32'(dif.segment[7]), 32'h0);
    $display("tb: heartbeat dp=%0b", dif.segment[7]);
`endif

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_msg_sequencer.md
Name: disp_msg_sequencer

Overview:
Controller for the 4-digit multiplexed seven-segment display and the buzzer on the front-panel board.
- Accepts five debounced button levels (err, off, on, open, sound).
- Arbitrates new presses into a single held message code.
- Scans the message across the four digits using a refresh counter.
- Schedules a beep pattern per event.
- Sits between the debouncer bank and the physical digit, segment and buzzer pins.

Parameters:
- REFRESH_DIV, default 50000: clk cycles each digit stays enabled; valid range ≥ 2.
- BEEP_CYCLES, default 5000000: clk cycles per beep-on phase and per gap phase; valid range ≥ 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  5  debounced levels: bit0 err, bit1 off, bit2 on, bit3 open, bit4 sound.
- digit  output  4  one-hot active-high digit enable; digit[3] is the leftmost character.
- segment  output  8  active-low {dp,g,f,e,d,c,b,a}.
- buzzer  output  1  active-high buzzer drive.
- msg_code  output  3  held message: 000 err, 001 off, 010 on, 011 open, 100 sound, 111 blank.
- busy  output  1  high while a beep pattern is in progress.

Behaviour:
- Reset (asynchronous, active-high):
  - digit=0000, segment=8'hFF, buzzer=0, msg_code=111, busy=0.
  - Scan index=0, refresh and beep counters=0, req_q=00000.
- Event detection: rise = req & ~req_q, with req_q registered each cycle.
- Arbitration: on any rise, accept only the highest-priority bit: err > off > on > open > sound. Rises on lower-priority bits in the same cycle are dropped.
- msg_code updates on the edge following the rise cycle (1-cycle latency). It holds until the next accepted event.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1.
  - At terminal count it wraps to 0 and the scan index advances 0→1→2→3→0.
- Scan index i maps to digit = 4'b1000 >> i and character position i (0 = leftmost).
- digit and segment are both registered from the same scan index on the same edge, so there is no ghosting.
  - Outputs of the first edge after reset release: digit=1000, segment=FF.
- Messages, left to right:
  - err = "Err " (86,AF,AF,FF)
  - off = " OFF" (FF,C0,8E,8E)
  - on = "  On" (FF,FF,C0,AB)
  - open = "OPEn" (C0,8C,86,AB)
  - sound = "Snd " (92,AB,A1,FF)
  - blank = FF×4
  - dp stays 1 (off) for all glyphs.
- Beep FSM has states IDLE, BEEP, GAP.
  - Beep count per event: err=2, sound=3, all other events=1.
  - On an accepted event: load remaining=count, zero the beep counter, enter BEEP. This happens in the same edge as the msg_code update.
  - BEEP: buzzer=1 for BEEP_CYCLES cycles, then decrement remaining.
    - If remaining is now 0, go to IDLE.
    - Otherwise go to GAP.
  - GAP: buzzer=0 for BEEP_CYCLES cycles, then return to BEEP.
  - busy=1 in BEEP and GAP; busy=0 in IDLE.
- Preemption: an accepted event while busy restarts the FSM in BEEP with the new count and updates msg_code immediately. The old pattern is abandoned.
- Held button: a held level produces no further events. Only the next 0→1 transition counts.
- Reset mid-pattern or mid-scan: all outputs return to their reset values immediately, with no partial beep.

Optional Feature:
- Macro: DISP_DP_HEARTBEAT_EN.
- Defined:
  - A frame counter increments each time the scan index wraps 3→0.
  - The dp bit of the rightmost digit (i=3) is driven low (lit) while frame counter bit 7 is 1, giving a toggle every 128 frames.
  - The frame counter resets to 0.
- Undefined: dp is always 1. No frame counter exists.

Test Plan:
1. Reset and blank scan (REFRESH_DIV=4): release rst, no req → msg_code=111, segment=FF. digit cycles 1000,0100,0010,0001 with 4 cycles each, then wraps to 1000.
2. Single on press (BEEP_CYCLES=8): req=00100 held for 20 cycles → msg_code=010 one cycle after the rise. Scanned segments FF,FF,C0,AB. buzzer high for exactly 8 cycles, then busy=0. No second event while held.
3. Simultaneous rise req=00011 → msg_code=000 and two beeps (8 on, 8 off, 8 on); the off event is dropped.
4. Sound pattern → buzzer shows 3 beeps with 2 gaps, and busy is high for 40 cycles.
5. Preemption: sound accepted, err rises during the second beep → msg_code=000, and a fresh 2-beep pattern starts on the next edge.
6. rst asserted mid-beep and mid-scan → buzzer=0, busy=0, digit=0000, segment=FF, msg_code=111 asynchronously. With DISP_DP_HEARTBEAT_EN defined, digit 0001's segment[7]=0 after 128 frames.
